// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the pattern detector.
//   DEF_PAT_W      : default pattern length in bits
//   DEF_CNT_W      : default match counter width
//   overlap_mode_e : match mode; OVERLAP keeps the history fill after a
//                    match, NON_OVERLAP restarts it
package pattern_detector_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } overlap_mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, count -> 0
//   clr   : zero the count; an inc in the same cycle leaves the count at 1
//   inc   : add one, holding at all-ones instead of wrapping
//   count : current count
//   sat   : high while count is all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with per-bit don't-care mask.
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   in_valid, in_bit  : serial input; in_bit is sampled only when in_valid
//   cfg_load          : latch cfg_pattern/cfg_mask/cfg_overlap and restart
//                       the history; the input bit of that cycle is dropped
//   cfg_pattern       : pattern, bit 0 is the most recent bit
//   cfg_mask          : 1 = compare this bit, 0 = don't-care
//   cfg_overlap       : 1 = overlapping matches, 0 = non-overlapping
//   clr_count         : zero the match counter
//   detected          : registered one-cycle pulse per match
//   match_count       : saturating number of matches
//   count_sat         : high while match_count is all-ones
//   armed             : high while the history holds PAT_W valid bits
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int               PAT_W     = DEF_PAT_W,
    parameter int               CNT_W     = DEF_CNT_W,
    parameter logic [PAT_W-1:0] RESET_PAT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             clr_count,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic             armed
);

    // fill counts 0..PAT_W inclusive, so it needs one more code than PAT_W.
    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  history;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  mask_q;
    overlap_mode_e     mode_q;

    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              bits_ok;
    logic              match;
    logic [PAT_W-1:0]  history_d;
    logic [FILL_W-1:0] fill_d;

    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        hist_shift = {history[PAT_W-2:0], in_bit};
        fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        bits_ok    = ((hist_shift ~^ pattern_q) & mask_q) == mask_q;
        // fill_inc already counts the current bit, so "full" here means the
        // post-shift history holds PAT_W valid bits.
        match      = in_valid && !cfg_load && (fill_inc == FILL_FULL) && bits_ok;

        history_d  = history;
        fill_d     = fill;
        if (cfg_load) begin
            history_d = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            history_d = hist_shift;
            fill_d    = (match && mode_q == NON_OVERLAP) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            history   <= '0;
            fill      <= '0;
            pattern_q <= RESET_PAT;
            mask_q    <= '1;
            mode_q    <= OVERLAP;
            detected  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            history  <= history_d;
            fill     <= fill_d;
            detected <= match;
            // Tracks the register it describes: armed == (fill == PAT_W).
            armed    <= (fill_d == FILL_FULL);
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                mask_q    <= cfg_mask;
                mode_q    <= overlap_mode_e'(cfg_overlap);
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_count),
        .inc   (match),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 8: pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 16: width of the match counter.
REQ-003 SHALL have parameter RESET_PAT, default all-zeros of PAT_W bits: pattern loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: in_bit is sampled only when this is high.
REQ-007 SHALL have port in_bit, input, 1 bit: serial data bit.
REQ-008 SHALL have port cfg_load, input, 1 bit: load configuration this cycle.
REQ-009 SHALL have port cfg_pattern, input, PAT_W bits: pattern; bit 0 is the most recent bit.
REQ-010 SHALL have port cfg_mask, input, PAT_W bits: 1 means compare this bit, 0 means don't-care.
REQ-011 SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping mode, 0 selects non-overlapping mode.
REQ-012 SHALL have port clr_count, input, 1 bit: clear the match counter.
REQ-013 SHALL have port detected, output, 1 bit: one-cycle match pulse.
REQ-014 SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-015 SHALL have port count_sat, output, 1 bit: high while match_count is all-ones.
REQ-016 SHALL have port armed, output, 1 bit: high while the history holds PAT_W valid bits.

Function
REQ-017 On each in_valid, the block SHALL shift in_bit into history at bit 0, with older bits moving toward bit PAT_W-1.
REQ-018 A fill counter SHALL count valid bits from 0 to PAT_W and saturate at PAT_W.
REQ-019 A match SHALL be evaluated on each in_valid cycle against the post-shift history and SHALL require both:
- fill including the current bit >= PAT_W;
- ((history XNOR pattern) AND mask) equal to mask.
REQ-020 detected SHALL be registered: it pulses for one cycle, in the cycle after the in_valid cycle that completes the match.
REQ-021 When in_valid is low, history, fill and detected SHALL be unaffected (detected is 0); stalls SHALL NOT break a partial sequence.
REQ-022 Overlapping mode: fill SHALL be unchanged on a match, so the next match can occur on the next valid bit.
REQ-023 Non-overlapping mode: on a match, fill SHALL reset to 0, so the next match needs PAT_W fresh bits.
REQ-024 An all-zero mask SHALL match on every valid bit once fill reaches PAT_W.
REQ-025 cfg_load SHALL behave as follows:
- latch pattern, mask and overlap;
- clear history and fill;
- ignore in_bit in that cycle, with no match evaluated;
- leave match_count unchanged.
REQ-026 Each match SHALL increment match_count by 1; the counter saturates at 2^CNT_W-1 and never wraps.
REQ-027 clr_count SHALL zero match_count; a match in the same cycle SHALL leave match_count at 1.
REQ-028 If cfg_load and clr_count are asserted together, both actions SHALL take effect.
REQ-029 armed SHALL equal (fill == PAT_W) and be registered.

Reset
REQ-030 While rst is high, the block SHALL set the following, with rst overriding every other input, including mid-sequence:
- history = 0, fill = 0;
- pattern = RESET_PAT, mask = all-ones, overlap = 1;
- detected = 0, match_count = 0, count_sat = 0, armed = 0.
REQ-031 The first bit that can contribute to a match after reset SHALL be the first in_valid bit in the cycle after rst is released.

Structure
REQ-032 A shared package pattern_detector_pkg SHALL hold the PAT_W/CNT_W defaults and the mode constants OVERLAP and NON_OVERLAP.
REQ-033 The match counter SHALL be the sub-module sat_counter: parameter W, with inputs clr, inc and outputs count, sat.
REQ-034 The block SHALL use single-clock logic only, with no latches.

Verification (PAT_W=4, CNT_W=2 unless stated)
REQ-035 Pattern 1011, mask 1111, overlap, stream 1,0,1,1,0,1,1 (all valid) -> detected after bits 4 and 7; match_count = 2.
REQ-036 Same stream in non-overlap mode -> detected after bit 4 only; match_count = 1.
REQ-037 Pattern 1001, mask 1011, stream 1,1,0,1 -> detected after bit 4, because bit 2 is don't-care.
REQ-038 Stream 1,0,1,1 with in_valid low for 3 cycles between each bit, pattern 1011 -> single detected pulse, one cycle after the last valid bit.
REQ-039 Five matches in overlap mode with an all-zero mask -> match_count = 3, count_sat = 1; then clr_count together with a match -> match_count = 1.
REQ-040 rst asserted after bits 1,0,1 of pattern 1011, then stream 1 -> no detected; armed = 0; pattern is back to RESET_PAT.
